// File: rtl/edge_trigger_pkg.sv
// edge_trigger_pkg: shared mode constants and channel state encoding
package edge_trigger_pkg;
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;
  typedef enum logic {WAITING = 1'b0, TRIGGERED = 1'b1} trig_state_t;
endpackage

// File: rtl/edge_trigger_channel.sv
// edge_trigger_channel: synchronised edge detector with a sticky trigger flag
module edge_trigger_channel
  import edge_trigger_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       signal,
  input  logic [1:0] mode,
  output logic       state,
  output logic       fire
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev, sync_out, match;
  trig_state_t cur, nxt;
  assign sync_out = sync[SYNC_STAGES-1];
  assign state = cur;
  // synchroniser and edge history; clear leaves them alone so a held level needs a fresh edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= SYNC_STAGES'({sync, signal});
      prev <= sync_out;
    end
  end
  // edge decode and sticky next state; clear beats a coincident edge
  always_comb begin
    match = mode == MODE_RISE ? (!prev && sync_out) :
            mode == MODE_FALL ? (prev && !sync_out) :
            mode == MODE_BOTH ? (prev != sync_out) : 1'b0;
    fire  = (cur == WAITING) && match && !clear;
    nxt   = clear ? WAITING : fire ? TRIGGERED : cur;
  end
  // channel state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= WAITING;
    else cur <= nxt;
  end
endmodule

// File: rtl/edge_trigger_bank.sv
// edge_trigger_bank: multi-channel sticky edge triggers with first-event timestamp capture
module edge_trigger_bank
  import edge_trigger_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TS_WIDTH    = 32
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          clear,
  input  logic [CHANNELS-1:0]                           signal,
  input  logic [2*CHANNELS-1:0]                         mode,
  output logic [CHANNELS-1:0]                           state,
  output logic                                          any_trig,
  output logic                                          capture_valid,
  output logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] first_chan,
  output logic [CHANNELS-1:0]                           first_mask,
  output logic [TS_WIDTH-1:0]                           ts_capture
);
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  logic [CHANNELS-1:0] fire;
  logic [TS_WIDTH-1:0] count;
  logic [CW-1:0] low;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_trigger_channel #(.SYNC_STAGES(SYNC_STAGES)) u_ch (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .signal(signal[i]),
      .mode  (mode[2*i +: 2]),
      .state (state[i]),
      .fire  (fire[i])
    );
  end
  // lowest-index channel among those firing this cycle
  always_comb begin
    low = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) if (fire[i]) low = CW'(i);
  end
  // free-running counter, summary flag and first-trigger capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset || clear) begin
      count         <= '0;
      any_trig      <= 1'b0;
      capture_valid <= 1'b0;
      first_chan    <= '0;
      first_mask    <= '0;
      ts_capture    <= '0;
    end else begin
      count    <= count + 1'b1;
      any_trig <= |(state | fire);
      if (!capture_valid && |fire) begin
        capture_valid <= 1'b1;
        first_chan    <= low;
        first_mask    <= fire;
        ts_capture    <= count;
      end
    end
  end
endmodule

// File: tb/tb_edge_trigger_bank.sv
// tb_edge_trigger_bank: table-driven check of triggers, capture, clear collision, wrap and async reset
module tb_edge_trigger_bank;
  logic       clk, reset, clear;
  logic [3:0] signal;
  logic [7:0] mode;
  logic [3:0] state, state1, first_mask, first_mask1;
  logic       any_trig, any_trig1, capture_valid, capture_valid1;
  logic [1:0] first_chan, first_chan1;
  logic [31:0] ts_capture;
  logic [3:0]  ts_capture1;
  int errors = 0, checks = 0;

  typedef struct {
    logic        clr;
    logic [3:0]  sig;
    logic [7:0]  md;
    logic [3:0]  st;
    logic        cv;
    logic [1:0]  fc;
    logic [3:0]  fm;
    logic [31:0] ts;
  } vec_t;
  vec_t tbl[$];

  edge_trigger_bank u0 (
    .clk(clk), .reset(reset), .clear(clear), .signal(signal), .mode(mode),
    .state(state), .any_trig(any_trig), .capture_valid(capture_valid),
    .first_chan(first_chan), .first_mask(first_mask), .ts_capture(ts_capture)
  );
  edge_trigger_bank #(.TS_WIDTH(4)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .signal(signal), .mode(mode),
    .state(state1), .any_trig(any_trig1), .capture_valid(capture_valid1),
    .first_chan(first_chan1), .first_mask(first_mask1), .ts_capture(ts_capture1)
  );

  always #5 clk = ~clk;

  function automatic void add(input int n, input logic clr, input logic [3:0] sig, input logic [7:0] md,
                              input logic [3:0] st, input logic cv, input logic [1:0] fc,
                              input logic [3:0] fm, input logic [31:0] ts);
    vec_t v;
    v.clr = clr; v.sig = sig; v.md = md; v.st = st; v.cv = cv; v.fc = fc; v.fm = fm; v.ts = ts;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] st, input logic cv, input logic [1:0] fc,
                           input logic [3:0] fm, input logic [31:0] ts);
    logic [31:0] ts16;
    ts16 = ts & 32'hF;
    chk({tag, " state"}, {28'd0, state}, {28'd0, st});
    chk({tag, " any_trig"}, {31'd0, any_trig}, {31'd0, |st});
    chk({tag, " capture_valid"}, {31'd0, capture_valid}, {31'd0, cv});
    chk({tag, " first_chan"}, {30'd0, first_chan}, {30'd0, fc});
    chk({tag, " first_mask"}, {28'd0, first_mask}, {28'd0, fm});
    chk({tag, " ts_capture"}, ts_capture, ts);
    chk({tag, " state(ts4)"}, {28'd0, state1}, {28'd0, st});
    chk({tag, " ts_capture(ts4)"}, {28'd0, ts_capture1}, ts16);
  endtask

  task automatic step(input logic clr, input logic [3:0] sig, input logic [7:0] md);
    clear = clr; signal = sig; mode = md;
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      step(tbl[i].clr, tbl[i].sig, tbl[i].md);
      check_all($sformatf("row%0d", i), tbl[i].st, tbl[i].cv, tbl[i].fc, tbl[i].fm, tbl[i].ts);
    end
  endtask

  initial begin
    int s1, s2, s3, s4, s5;
    clk = 0; reset = 1; clear = 0; signal = '0; mode = '0;
    s1 = 0;
    add(1, 1, 4'h0, 8'h10, 4'h0, 0, 0, 4'h0, 0);
    add(9, 0, 4'h0, 8'h10, 4'h0, 0, 0, 4'h0, 0);
    add(2, 0, 4'h4, 8'h10, 4'h0, 0, 0, 4'h0, 0);
    add(2, 0, 4'h4, 8'h10, 4'h4, 1, 2, 4'h4, 11);
    s2 = tbl.size();
    add(1, 1, 4'h0, 8'h0E, 4'h0, 0, 0, 4'h0, 0);
    add(2, 0, 4'h0, 8'h0E, 4'h0, 0, 0, 4'h0, 0);
    add(2, 0, 4'hF, 8'h0E, 4'h0, 0, 0, 4'h0, 0);
    add(1, 0, 4'hF, 8'h0E, 4'h2, 1, 1, 4'h2, 4);
    add(2, 0, 4'h0, 8'h0E, 4'h2, 1, 1, 4'h2, 4);
    add(2, 0, 4'h0, 8'h0E, 4'h3, 1, 1, 4'h2, 4);
    s3 = tbl.size();
    add(1, 1, 4'h0, 8'h45, 4'h0, 0, 0, 4'h0, 0);
    add(1, 0, 4'h0, 8'h45, 4'h0, 0, 0, 4'h0, 0);
    add(2, 0, 4'hA, 8'h45, 4'h0, 0, 0, 4'h0, 0);
    add(1, 0, 4'hA, 8'h45, 4'hA, 1, 1, 4'hA, 3);
    add(2, 0, 4'hB, 8'h45, 4'hA, 1, 1, 4'hA, 3);
    add(1, 0, 4'hB, 8'h45, 4'hB, 1, 1, 4'hA, 3);
    s4 = tbl.size();
    add(1, 1, 4'h0, 8'h01, 4'h0, 0, 0, 4'h0, 0);
    add(1, 0, 4'h0, 8'h01, 4'h0, 0, 0, 4'h0, 0);
    add(2, 0, 4'h1, 8'h01, 4'h0, 0, 0, 4'h0, 0);
    add(1, 1, 4'h1, 8'h01, 4'h0, 0, 0, 4'h0, 0);
    add(3, 0, 4'h1, 8'h01, 4'h0, 0, 0, 4'h0, 0);
    add(2, 0, 4'h0, 8'h01, 4'h0, 0, 0, 4'h0, 0);
    add(2, 0, 4'h1, 8'h01, 4'h0, 0, 0, 4'h0, 0);
    add(1, 0, 4'h1, 8'h01, 4'h1, 1, 0, 4'h1, 7);
    s5 = tbl.size();
    #12;
    check_all("reset", 4'h0, 0, 0, 4'h0, 0);
    reset = 0;
    run_rows(s1, s5);
    step(1, 4'h0, 8'h01);
    repeat (19) step(0, 4'h0, 8'h01);
    step(0, 4'h1, 8'h01);
    step(0, 4'h1, 8'h01);
    check_all("wrap pre", 4'h0, 0, 0, 4'h0, 0);
    step(0, 4'h1, 8'h01);
    check_all("wrap", 4'h1, 1, 0, 4'h1, 21);
    #2 reset = 1;
    #1 check_all("async_reset", 4'h0, 0, 0, 4'h0, 0);
    @(negedge clk);
    check_all("reset held", 4'h0, 0, 0, 4'h0, 0);
    reset = 0;
    run_rows(s1, s2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/edge_trigger_bank.md
# edge_trigger_bank

Multi-channel, parametrised trigger unit for the real-time feedback path: each channel synchronises an asynchronous input, detects a configurable edge (rising, falling or either) and latches a sticky triggered state until cleared. A free-running timestamp counter records the time of, and channels involved in, the first trigger after a clear, so downstream logic can order events across channels. It replaces single-channel rising-edge detectors wherever several inputs are watched together.

## Interface
- `CHANNELS`, 4: number of independent input channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥1).
- `TS_WIDTH`, 32: timestamp counter width (≥2).
- `clk`  in  1: single clock, all logic on rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `clear`  in  1: synchronous re-arm of all channels and the capture; restarts the counter.
- `signal`  in  CHANNELS: asynchronous monitored inputs.
- `mode`  in  2*CHANNELS: per-channel edge select, bits [2i+1:2i] for channel i.
- `state`  out  CHANNELS: sticky per-channel triggered flag (1 = TRIGGERED).
- `any_trig`  out  1: OR of `state`, registered with it.
- `capture_valid`  out  1: first-trigger capture holds data.
- `first_chan`  out  $clog2(CHANNELS) (min 1): lowest-index channel of the first trigger.
- `first_mask`  out  CHANNELS: all channels that triggered in the first-trigger cycle.
- `ts_capture`  out  TS_WIDTH: counter value at first trigger.

## Operation
- Per channel: `SYNC_STAGES`-deep synchroniser → `sync_out`; `prev` = `sync_out` delayed one cycle.
- Mode: 00 OFF (no detection), 01 RISE (prev=0, sync_out=1), 10 FALL (prev=1, sync_out=0), 11 BOTH (prev≠sync_out). `mode` is sampled every cycle, not latched.
- Channel FSM: WAITING →(edge match)→ TRIGGERED; TRIGGERED holds until `clear` or `reset`. Switching to OFF does not drop an existing TRIGGERED.
- Counter: `count` increments by 1 every cycle, wraps modulo 2^TS_WIDTH with no flag; `clear` loads 0.
- Capture: on the first cycle after reset/clear in which ≥1 channel goes WAITING→TRIGGERED and `capture_valid`=0, load `ts_capture` ← current `count`, `first_mask` ← set of channels transitioning in that cycle, `first_chan` ← lowest set index of that set, `capture_valid` ← 1. Later triggers never change the capture.
- Simultaneous events: several channels in one cycle → all set in `first_mask`, lowest index in `first_chan`. `clear` and an edge in the same cycle → `clear` wins: state stays 0 and no capture. The edge is lost.
- `clear` does not flush synchronisers or `prev`. A level held across `clear` does not retrigger without a new edge.
- `reset` (any time, mid-operation included): `state`, `any_trig`, `capture_valid`, `first_chan`, `first_mask`, `ts_capture`, `count`, synchroniser and `prev` flops all → 0.

## Timing
- An input first sampled at a new level on edge n sets `state` at edge n+SYNC_STAGES. It gets `ts_capture` = `count` during the preceding cycle.
- With `count` = 0 after the `clear` edge, a rising input first sampled at edge j after clear gives `ts_capture` = j+SYNC_STAGES−1.
- `any_trig`, `capture_valid`, `first_*`, `ts_capture` update on the same edge as `state`. All outputs are registered, with no combinational input→output path.
- `clear` takes effect on the edge it is sampled. Outputs read 0 from the next cycle, and detection resumes the cycle after.
- Pulses shorter than one clock period are not guaranteed to be seen.

## Structure
- Package `edge_trigger_pkg`: mode constants `MODE_OFF/RISE/FALL/BOTH` (2-bit), state encoding `WAITING=0`, `TRIGGERED=1`.
- Sub-module `edge_trigger_channel`: synchroniser, `prev`, mode decode, sticky FSM. It outputs `state` and a one-cycle `fire` (WAITING→TRIGGERED this cycle).
- Top: CHANNELS × `edge_trigger_channel` via generate, counter, lowest-index priority encoder over `fire`, capture registers.

## Test plan
- Rising, CHANNELS=4, SYNC_STAGES=2: `clear` at edge 0, ch2 RISE, signal[2] first sampled high at edge 10 → state=4'b0100 at edge 12, `first_chan`=2, `first_mask`=4'b0100, `ts_capture`=11.
- Falling/both: ch0 FALL, ch1 BOTH, ch3 OFF. Toggle all high then low → ch1 sets on the rise, ch0 on the fall, ch3 never; capture reports ch1 only.
- Simultaneous: ch1 and ch3 RISE, same-cycle edge → `first_mask`=4'b1010, `first_chan`=1. A later ch0 trigger leaves the capture unchanged.
- Clear collision: edge detection cycle coincides with `clear` → state 0, `capture_valid`=0. A held-high input does not retrigger, and the next rising edge does.
- Wrap: TS_WIDTH=4, trigger 20 cycles after clear → `ts_capture`=(20+SYNC_STAGES−1) mod 16.
- Async reset mid-operation, asserted between clock edges after a trigger → all outputs 0 immediately, without waiting for a clock edge. Post-release behaviour matches the first scenario.
